// File: rtl/iob_fifo_sync_asym_if.sv
// rtl/iob_fifo_sync_asym_if.sv - write/read handshake bundle for iob_fifo_sync_asym
// master drives requests and data; slave is the FIFO side.
interface iob_fifo_sync_asym_if #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
);
  logic                w_en;
  logic [W_DATA_W-1:0] w_data;
  logic                w_full;
  logic                r_en;
  logic [R_DATA_W-1:0] r_data;
  logic                r_empty;
  logic [ADDR_W:0]     level;
  logic                almost_empty;
  logic                almost_full;
  logic                err_clr;
  logic                w_ovf;
  logic                r_udf;

  modport master (
    output w_en, w_data, r_en, err_clr,
    input  w_full, r_data, r_empty, level, almost_empty, almost_full, w_ovf, r_udf
  );

  modport slave (
    input  w_en, w_data, r_en, err_clr,
    output w_full, r_data, r_empty, level, almost_empty, almost_full, w_ovf, r_udf
  );
endinterface

// File: rtl/iob_fifo_sync_asym.sv
// rtl/iob_fifo_sync_asym.sv - single-clock FIFO with asymmetric write/read widths
// Sticky overflow/underflow flags are built only with IOB_FIFO_SYNC_ASYM_ERR_EN defined.
module iob_fifo_sync_asym #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4,
  parameter int AE_THR   = 1,
  parameter int AF_THR   = 12
) (
  input logic                 clk,
  input logic                 rst,
  iob_fifo_sync_asym_if.slave fifo_if
);
  localparam int MIN_W   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int MAX_W   = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int RATIO   = MAX_W / MIN_W;
  localparam int SIZE    = 2 ** ADDR_W;
  localparam int W_INCR  = (W_DATA_W > R_DATA_W) ? RATIO : 1;
  localparam int R_INCR  = (R_DATA_W > W_DATA_W) ? RATIO : 1;
  localparam int W_SHIFT = $clog2(W_INCR);
  localparam int R_SHIFT = $clog2(R_INCR);
  localparam int W_PTR_W = ADDR_W - W_SHIFT;
  localparam int R_PTR_W = ADDR_W - R_SHIFT;
  localparam int LVL_W   = ADDR_W + 1;

  localparam logic [LVL_W-1:0] SIZE_L   = LVL_W'(SIZE);
  localparam logic [LVL_W-1:0] W_INCR_L = LVL_W'(W_INCR);
  localparam logic [LVL_W-1:0] R_INCR_L = LVL_W'(R_INCR);
  localparam logic [LVL_W-1:0] AE_L     = LVL_W'(AE_THR);
  localparam logic [LVL_W-1:0] AF_L     = LVL_W'(AF_THR);

  // storage is kept in min-width units so either port can address it directly
  logic [MIN_W-1:0]    mem [SIZE];
  logic [W_PTR_W-1:0]  w_ptr;
  logic [R_PTR_W-1:0]  r_ptr;
  logic [ADDR_W-1:0]   w_base;
  logic [ADDR_W-1:0]   r_base;
  logic [LVL_W-1:0]    level_q;
  logic [LVL_W-1:0]    level_nxt;
  logic [R_DATA_W-1:0] r_data_q;
  logic                w_full;
  logic                r_empty;
  logic                w_en_int;
  logic                r_en_int;

  assign w_full   = level_q > (SIZE_L - W_INCR_L);
  assign r_empty  = level_q < R_INCR_L;
  assign w_en_int = fifo_if.w_en & ~w_full;
  assign r_en_int = fifo_if.r_en & ~r_empty;

  assign w_base = ADDR_W'(w_ptr) << W_SHIFT;
  assign r_base = ADDR_W'(r_ptr) << R_SHIFT;

  assign level_nxt = level_q
                   + (w_en_int ? W_INCR_L : '0)
                   - (r_en_int ? R_INCR_L : '0);

  // little-endian: unit i of a wide word sits at base + i
  always_ff @(posedge clk) begin
    if (w_en_int && !rst) begin
      for (int i = 0; i < W_INCR; i++) begin
        mem[w_base + ADDR_W'(i)] <= fifo_if.w_data[i*MIN_W +: MIN_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      level_q  <= '0;
      r_data_q <= '0;
    end else begin
      if (w_en_int) begin
        w_ptr <= w_ptr + W_PTR_W'(1);
      end
      if (r_en_int) begin
        r_ptr <= r_ptr + R_PTR_W'(1);
        for (int i = 0; i < R_INCR; i++) begin
          r_data_q[i*MIN_W +: MIN_W] <= mem[r_base + ADDR_W'(i)];
        end
      end
      level_q <= level_nxt;
    end
  end

`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
  logic w_ovf_q;
  logic r_udf_q;

  // a new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ovf_q <= 1'b0;
      r_udf_q <= 1'b0;
    end else begin
      if (fifo_if.w_en && w_full) begin
        w_ovf_q <= 1'b1;
      end else if (fifo_if.err_clr) begin
        w_ovf_q <= 1'b0;
      end
      if (fifo_if.r_en && r_empty) begin
        r_udf_q <= 1'b1;
      end else if (fifo_if.err_clr) begin
        r_udf_q <= 1'b0;
      end
    end
  end

  assign fifo_if.w_ovf = w_ovf_q;
  assign fifo_if.r_udf = r_udf_q;
`else
  wire unused_err_clr = fifo_if.err_clr;

  assign fifo_if.w_ovf = 1'b0;
  assign fifo_if.r_udf = 1'b0;
`endif

  assign fifo_if.w_full       = w_full;
  assign fifo_if.r_empty      = r_empty;
  assign fifo_if.r_data       = r_data_q;
  assign fifo_if.level        = level_q;
  assign fifo_if.almost_empty = level_q <= AE_L;
  assign fifo_if.almost_full  = level_q >= AF_L;
endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// tb/tb_iob_fifo_sync_asym.sv - directed bench for iob_fifo_sync_asym (32->8 and 8->32)
module tb_iob_fifo_sync_asym;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;

`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
  localparam logic [63:0] ERR_EXP = 64'd1;
`else
  localparam logic [63:0] ERR_EXP = 64'd0;
`endif

  always #5 clk = ~clk;

  iob_fifo_sync_asym_if #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) a_if ();
  iob_fifo_sync_asym_if #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) b_if ();

  iob_fifo_sync_asym #(
    .W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4), .AE_THR(1), .AF_THR(12)
  ) dut_a (
    .clk(clk), .rst(rst), .fifo_if(a_if)
  );

  iob_fifo_sync_asym #(
    .W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .AE_THR(1), .AF_THR(12)
  ) dut_b (
    .clk(clk), .rst(rst), .fifo_if(b_if)
  );

  logic [7:0] b_bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] q [$];
  logic [7:0] exp_byte;
  logic       wacc;
  logic       racc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [31:0] d);
    a_if.w_en   = 1'b1;
    a_if.w_data = d;
    tick();
    a_if.w_en   = 1'b0;
  endtask

  task automatic a_read();
    a_if.r_en = 1'b1;
    tick();
    a_if.r_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_if.w_en = 1'b0; a_if.w_data = '0; a_if.r_en = 1'b0; a_if.err_clr = 1'b0;
    b_if.w_en = 1'b0; b_if.w_data = '0; b_if.r_en = 1'b0; b_if.err_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_level",  64'(a_if.level), 64'd0);
    check("rst_empty",  64'(a_if.r_empty), 64'd1);
    check("rst_full",   64'(a_if.w_full), 64'd0);
    check("rst_ae",     64'(a_if.almost_empty), 64'd1);
    check("rst_af",     64'(a_if.almost_full), 64'd0);
    check("rst_rdata",  64'(a_if.r_data), 64'd0);
    check("rst_ovf",    64'(a_if.w_ovf), 64'd0);
    check("rst_udf",    64'(a_if.r_udf), 64'd0);
    check("b_rst_empty", 64'(b_if.r_empty), 64'd1);

    // narrow writes packed into one wide read
    for (int i = 0; i < 4; i++) begin
      b_if.w_en   = 1'b1;
      b_if.w_data = b_bytes[i];
      tick();
      check("b_empty", 64'(b_if.r_empty), (i < 3) ? 64'd1 : 64'd0);
    end
    b_if.w_en = 1'b0;
    check("b_level", 64'(b_if.level), 64'd4);
    b_if.r_en = 1'b1;
    tick();
    b_if.r_en = 1'b0;
    check("b_rdata", 64'(b_if.r_data), 64'hDDCCBBAA);
    check("b_empty_after", 64'(b_if.r_empty), 64'd1);

    // wide write, narrow reads
    a_write(32'h44332211);
    check("w1_level", 64'(a_if.level), 64'd4);
    check("w1_empty", 64'(a_if.r_empty), 64'd0);
    check("w1_ae",    64'(a_if.almost_empty), 64'd0);
    for (int k = 0; k < 4; k++) begin
      a_read();
      check("rd_byte", 64'(a_if.r_data), 64'(8'h11 * (k + 1)));
    end
    check("rd_level", 64'(a_if.level), 64'd0);
    check("rd_empty", 64'(a_if.r_empty), 64'd1);

    // read on empty
    a_read();
    check("udf_rdata", 64'(a_if.r_data), 64'h44);
    check("udf_level", 64'(a_if.level), 64'd0);
    check("udf_flag",  64'(a_if.r_udf), ERR_EXP);
    a_if.err_clr = 1'b1;
    tick();
    a_if.err_clr = 1'b0;
    check("udf_clr", 64'(a_if.r_udf), 64'd0);

    // fill to full, then a dropped write
    for (int i = 0; i < 4; i++) begin
      a_write(32'h13121110 + 32'(i) * 32'h10101010);
    end
    check("fill_level", 64'(a_if.level), 64'd16);
    check("fill_full",  64'(a_if.w_full), 64'd1);
    check("fill_af",    64'(a_if.almost_full), 64'd1);
    a_write(32'hDEADBEEF);
    check("ovf_level", 64'(a_if.level), 64'd16);
    check("ovf_flag",  64'(a_if.w_ovf), ERR_EXP);
    a_if.err_clr = 1'b1;
    tick();
    a_if.err_clr = 1'b0;
    check("ovf_clr", 64'(a_if.w_ovf), 64'd0);

    for (int k = 0; k < 12; k++) begin
      a_read();
      check("fill_byte", 64'(a_if.r_data), 64'((k / 4 + 1) * 16 + k % 4));
    end
    check("fill_rem", 64'(a_if.level), 64'd4);
    for (int j = 0; j < 4; j++) q.push_back(8'h40 + 8'(j));

    // simultaneous write and read across pointer wrap
    for (int c = 0; c < 10; c++) begin
      wacc = (q.size() <= 12);
      racc = (q.size() >= 1);
      a_if.w_en   = 1'b1;
      a_if.r_en   = 1'b1;
      a_if.w_data = 32'h83828180 + 32'(c) * 32'h04040404;
      tick();
      if (racc) begin
        exp_byte = q.pop_front();
        check("conc_byte", 64'(a_if.r_data), 64'(exp_byte));
      end
      if (wacc) begin
        for (int j = 0; j < 4; j++) q.push_back(8'h80 + 8'(4 * c + j));
      end
      if (c == 0) check("conc_lvl7", 64'(a_if.level), 64'd7);
      check("conc_level", 64'(a_if.level), 64'(q.size()));
    end
    a_if.w_en = 1'b0;
    a_if.r_en = 1'b0;
    for (int n = 0; n < 17 && q.size() > 0; n++) begin
      a_read();
      exp_byte = q.pop_front();
      check("drain_byte", 64'(a_if.r_data), 64'(exp_byte));
    end
    check("drain_level", 64'(a_if.level), 64'd0);
    check("drain_empty", 64'(a_if.r_empty), 64'd1);

    // reset with level 9 and a write pending
    for (int i = 0; i < 3; i++) a_write(32'h0);
    for (int k = 0; k < 3; k++) a_read();
    check("pre_rst_level", 64'(a_if.level), 64'd9);
    rst         = 1'b1;
    a_if.w_en   = 1'b1;
    a_if.w_data = 32'hFFFFFFFF;
    tick();
    rst       = 1'b0;
    a_if.w_en = 1'b0;
    check("mrst_level", 64'(a_if.level), 64'd0);
    check("mrst_empty", 64'(a_if.r_empty), 64'd1);
    check("mrst_rdata", 64'(a_if.r_data), 64'd0);
    check("mrst_ae",    64'(a_if.almost_empty), 64'd1);
    a_write(32'h87654321);
    for (int k = 0; k < 4; k++) begin
      a_read();
      check("post_rst_byte", 64'(a_if.r_data), 64'(8'h21 + 8'(k) * 8'h22));
    end
    check("post_rst_level", 64'(a_if.level), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/iob_fifo_sync_asym.md
# iob_fifo_sync_asym

Single-clock FIFO with independent write and read data widths, programmable almost-empty/almost-full thresholds and optional sticky overflow/underflow error flags. It is the same-clock-domain successor of the asymmetric dual-clock FIFO. It needs no gray-code crossing and keeps one exact fill level. It sits between datapath stages of different widths inside one clock domain, for example a 32-bit bus to an 8-bit serializer or 8-bit bytes to a 64-bit packer.

## Interface
Parameters:
- W_DATA_W, 32, write word width; must be a power-of-two multiple or divisor of R_DATA_W.
- R_DATA_W, 8, read word width.
- ADDR_W, 4, log2 of capacity in MIN(W_DATA_W,R_DATA_W) units. Must satisfy ADDR_W > log2(MAX/MIN).
- AE_THR, 1, almost-empty threshold, in min-width units.
- AF_THR, 12, almost-full threshold, in min-width units.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request.
- w_data  in  W_DATA_W  write data.
- w_full  out  1  a full write word does not fit.
- r_en  in  1  read request.
- r_data  out  R_DATA_W  read data, registered.
- r_empty  out  1  less than one read word stored.
- level  out  ADDR_W+1  fill level in min-width units.
- almost_empty  out  1  level <= AE_THR.
- almost_full  out  1  level >= AF_THR.
- err_clr  in  1  clears the sticky error flags.
- w_ovf  out  1  sticky: write attempted while w_full.
- r_udf  out  1  sticky: read attempted while r_empty.

## Operation
- Derived constants:
  - SIZE = 2^ADDR_W.
  - R = MAX/MIN width ratio.
  - W_INCR = R if W_DATA_W > R_DATA_W, else 1.
  - R_INCR = R if R_DATA_W > W_DATA_W, else 1.
- Storage: the existing asymmetric two-port RAM, with both ports on clk. Write and read pointers are binary, in each port's own word units, and wrap modulo their depth.
- Accepted write: w_en_int = w_en & ~w_full. Accepted read: r_en_int = r_en & ~r_empty.
- Level update each cycle: level_nxt = level + (w_en_int ? W_INCR : 0) - (r_en_int ? R_INCR : 0). Computed in ADDR_W+1 bits; never exceeds SIZE and never goes negative.
- Flags, all combinational from the level register:
  - w_full = level > SIZE - W_INCR.
  - r_empty = level < R_INCR.
  - almost_empty and almost_full as defined in the port list.
- Byte order is little-endian:
  - Wide write, narrow reads: the first read returns w_data[R_DATA_W-1:0].
  - Narrow writes, wide read: the first written word lands in r_data[W_DATA_W-1:0].
- Equal widths: plain synchronous FIFO with R = 1.
- Simultaneous write and read in the same cycle:
  - Both are accepted if their individual flags allow.
  - A write at w_full is dropped even if a read occurs in the same cycle.
  - A read at r_empty is dropped even if a write occurs in the same cycle.
  - Same-cycle write-to-read bypass does not exist.
- Dropped operations: pointers, level and RAM contents are unchanged. r_data holds its value.

## Timing
- Write latency: level, w_full, almost_full and r_empty reflect an accepted write on the next cycle.
- Read latency: r_data is valid 1 cycle after an accepted read and holds until the next accepted read.
- Reset (rst = 1 at a posedge) forces the following on the next cycle, regardless of w_en/r_en in the same cycle:
  - Pointers and level = 0.
  - r_data = 0.
  - r_empty = 1, w_full = 0.
  - almost_empty = 1 (AE_THR >= 0), almost_full = (AF_THR == 0).
  - w_ovf = r_udf = 0.
- Reset mid-operation discards all stored data. RAM contents are not cleared but are unreachable.
- Wrap-around: pointers roll from depth-1 to 0 with no bubble. Level stays exact across the wrap.

## Configuration
- Macro IOB_FIFO_SYNC_ASYM_ERR_EN.
- Defined:
  - w_ovf sets on a cycle with w_en & w_full.
  - r_udf sets on a cycle with r_en & r_empty.
  - Both are visible the next cycle and stay set until err_clr or rst.
  - If err_clr and a new error occur in the same cycle, the flag stays set (set wins).
- Undefined: w_ovf and r_udf are tied to 0, err_clr is ignored, and no error registers are synthesized. Ports stay present so the interface is stable.

## Test plan
- W=32, R=8, ADDR_W=4, after rst:
  - write 0x44332211 -> next cycle level=4, r_empty=0.
  - then 4 reads -> r_data 0x11, 0x22, 0x33, 0x44, each 1 cycle after its r_en.
  - then level=0, r_empty=1.
- Fill 4 writes -> level=16, w_full=1, almost_full=1.
  - 5th write ignored, contents intact.
  - With ERR_EN, w_ovf=1 until err_clr pulse.
- Level 4, w_en and r_en in the same cycle -> level=7. Data order preserved across a pointer wrap after 10 such cycles.
- Read on empty FIFO -> r_data unchanged, level=0. With ERR_EN, r_udf=1. Without ERR_EN, r_udf=0.
- W=8, R=32:
  - write 0xAA, 0xBB, 0xCC -> r_empty stays 1.
  - 4th write 0xDD -> next cycle r_empty=0.
  - read -> r_data = 0xDDCCBBAA.
- Assert rst with level=9 and w_en=1 in the same cycle -> next cycle level=0, r_empty=1, r_data=0. Subsequent write/read round-trips correctly.
